// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and default widths for the MAC sequencer
package mac_pkg;

  localparam int DEF_DW   = 4;
  localparam int DEF_AW   = 3;
  localparam int DEF_ACCW = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// rtl/mac_seq_ctrl_if.sv - host, BRAM and result signals of the MAC sequencer
interface mac_seq_ctrl_if #(
  parameter int DW   = 4,
  parameter int AW   = 3,
  parameter int ACCW = 12
);

  logic            start;
  logic            abort;
  logic [AW-1:0]   base_addr;
  logic [AW:0]     len;
  logic            bram_en;
  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   dout_a;
  logic [DW-1:0]   dout_b;
  logic            busy;
  logic            res_valid;
  logic            res_ready;
  logic [ACCW-1:0] result;
  logic            ovf;

  // master is the sequencer itself; slave is the host/BRAM environment
  modport master (
    input  start, abort, base_addr, len, dout_a, dout_b, res_ready,
    output bram_en, bram_addr, busy, res_valid, result, ovf
  );

  modport slave (
    output start, abort, base_addr, len, dout_a, dout_b, res_ready,
    input  bram_en, bram_addr, busy, res_valid, result, ovf
  );

endinterface

// File: rtl/mac_mul_stage.sv
// rtl/mac_mul_stage.sv - registered unsigned DW x DW multiplier with valid, 1-cycle latency
module mac_mul_stage #(
  parameter int DW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            vin,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            vout,
  output logic [2*DW-1:0] p
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vout <= 1'b0;
      p    <= '0;
    end else begin
      vout <= vin && !flush;
      if (vin)
        p <= (2*DW)'(a) * (2*DW)'(b);
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - BRAM-fed MAC sequencer; define MAC_SAT_EN to saturate the accumulator on overflow
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int ACCW   = DEF_ACCW,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mac_seq_ctrl_if.master bus
);

  state_t state_q, state_d;

  logic [AW-1:0]     addr_q;
  logic [AW:0]       len_q;
  logic [AW:0]       cnt_q;
  logic [RD_LAT-1:0] vpipe_q;
  logic [ACCW-1:0]   acc_q;
  logic              ovf_q;
  logic              mul_vout;
  logic [2*DW-1:0]   prod;
  logic [ACCW:0]     sum;
  logic              accept, issue, last_issue, flush;

  assign accept     = (state_q == IDLE) && bus.start;
  assign issue      = (state_q == RUN);
  assign last_issue = issue && ((cnt_q + (AW+1)'(1)) == len_q);
  assign flush      = bus.abort && (state_q != IDLE);
  assign sum        = {1'b0, acc_q} + (ACCW+1)'(prod);

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.len == '0) ? DONE : RUN;
      RUN:     if (bus.abort) state_d = IDLE; else if (last_issue) state_d = DRAIN;
      // the product still in the multiplier is folded in on the same edge DONE is entered
      DRAIN:   if (bus.abort) state_d = IDLE; else if (vpipe_q == '0) state_d = DONE;
      DONE:    if (bus.abort || bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      vpipe_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      vpipe_q <= flush ? '0 : ((vpipe_q << 1) | RD_LAT'(issue));
      if (accept) begin
        addr_q <= bus.base_addr;
        len_q  <= bus.len;
        cnt_q  <= '0;
        acc_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (issue) begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q + (AW+1)'(1);
        end
        if (mul_vout) begin
`ifdef MAC_SAT_EN
          // a saturated acc at all-ones carries on any nonzero add, so it stays clamped
          acc_q <= sum[ACCW] ? '1 : sum[ACCW-1:0];
`else
          acc_q <= sum[ACCW-1:0];
`endif
          ovf_q <= ovf_q | sum[ACCW];
        end
      end
    end
  end

  mac_mul_stage #(.DW(DW)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .vin   (vpipe_q[RD_LAT-1]),
    .a     (bus.dout_a),
    .b     (bus.dout_b),
    .vout  (mul_vout),
    .p     (prod)
  );

  assign bus.bram_en   = issue;
  assign bus.bram_addr = addr_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.result    = acc_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - randomized self-checking bench for mac_seq_ctrl against an arithmetic reference
module tb_mac_seq_ctrl;

  localparam int DW = 4, AW = 3, ACCW = 8, RD_LAT = 1, DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.DW(DW), .AW(AW), .ACCW(ACCW)) bus ();

  mac_seq_ctrl #(.DW(DW), .AW(AW), .ACCW(ACCW), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] rd_a = '0, rd_b = '0;
  int addr_log[$];
  int vec = 0, errs = 0;

  // single-cycle-latency read-only BRAM pair plus an address monitor
  always @(posedge clk) begin
    if (bus.bram_en) begin
      addr_log.push_back(int'(bus.bram_addr));
      rd_a <= mem_a[bus.bram_addr];
      rd_b <= mem_b[bus.bram_addr];
    end
  end
  assign bus.dout_a = rd_a;
  assign bus.dout_b = rd_b;

  function automatic void model(input int base, input int n, output int res, output bit ov);
    longint acc = 0;
    longint lim = longint'(1) << ACCW;
    ov = 1'b0;
    for (int i = 0; i < n; i++) begin
      int ad = (base + i) % DEPTH;
      acc += longint'(mem_a[ad]) * longint'(mem_b[ad]);
      if (acc >= lim) begin
        ov = 1'b1;
`ifdef MAC_SAT_EN
        acc = lim - 1;
`else
        acc -= lim;
`endif
      end
    end
    res = int'(acc);
  endfunction

  task automatic fill_random(input int hi);
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = DW'($urandom_range(0, hi));
      mem_b[i] = DW'($urandom_range(0, hi));
    end
  endtask

  // starts a job (edge 0) and waits for res_valid; lat = edge index, -1 on timeout
  task automatic run_job(input int base, input int n, input bit with_abort,
                         output int lat, output int res, output bit ov);
    @(negedge clk);
    bus.base_addr = AW'(base);
    bus.len       = (AW+1)'(n);
    bus.start     = 1'b1;
    bus.abort     = with_abort;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin
        @(posedge clk);
        @(negedge clk);
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
      if (bus.res_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    res = int'(bus.result);
    ov  = bus.ovf;
  endtask

  task automatic accept_result();
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.res_ready = 1'b0;
    bus.base_addr = '0; bus.len = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (bus.bram_en !== 1'b0) begin errs++; $display("FAIL reset_bram_en got=%b exp=0", bus.bram_en); end
    vec++; if (bus.bram_addr !== '0) begin errs++; $display("FAIL reset_bram_addr got=%0d exp=0", bus.bram_addr); end
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    vec++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
    vec++; if (bus.result !== '0 || bus.ovf !== 1'b0) begin
      errs++; $display("FAIL reset_result got=%0d/%b exp=0/0", bus.result, bus.ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_known();
    int lat, res; bit ov;
    for (int i = 0; i < DEPTH; i++) begin mem_a[i] = DW'(i + 1); mem_b[i] = 4'd15; end
    run_job(0, 5, 1'b0, lat, res, ov);
    vec++; if (lat != 7) begin errs++; $display("FAIL known_latency got=%0d exp=7", lat); end
    vec++; if (res != 225) begin errs++; $display("FAIL known_result got=%0d exp=225", res); end
    vec++; if (ov !== 1'b0) begin errs++; $display("FAIL known_ovf got=%b exp=0", ov); end
    accept_result();
  endtask

  task automatic test_addr_wrap();
    int lat, res, eres, log0, bad; bit ov, eov;
    fill_random(15);
    log0 = addr_log.size();
    run_job(6, 4, 1'b0, lat, res, ov);
    model(6, 4, eres, eov);
    vec++; if (addr_log.size() - log0 != 4) begin
      errs++; $display("FAIL wrap_en_cycles got=%0d exp=4", addr_log.size() - log0);
    end
    bad = 0;
    for (int i = 0; i < 4 && log0 + i < addr_log.size(); i++)
      if (addr_log[log0 + i] != (6 + i) % DEPTH) bad++;
    vec++; if (bad != 0) begin errs++; $display("FAIL wrap_addr_seq got=%0d wrong exp=0 wrong (6,7,0,1)", bad); end
    vec++; if (res != eres || ov !== eov) begin
      errs++; $display("FAIL wrap_result got=%0d/%b exp=%0d/%b", res, ov, eres, eov);
    end
    accept_result();
  endtask

  task automatic test_overflow();
    int lat, res, exp_res; bit ov;
`ifdef MAC_SAT_EN
    exp_res = 255;
`else
    exp_res = 101;
`endif
    for (int i = 0; i < DEPTH; i++) begin mem_a[i] = 4'd15; mem_b[i] = 4'd15; end
    run_job(0, 5, 1'b0, lat, res, ov);
    vec++; if (res != exp_res) begin errs++; $display("FAIL ovf_result got=%0d exp=%0d", res, exp_res); end
    vec++; if (ov !== 1'b1) begin errs++; $display("FAIL ovf_flag got=%b exp=1", ov); end
    accept_result();
    mem_a[2] = 4'd3; mem_b[2] = 4'd2;
    run_job(2, 1, 1'b0, lat, res, ov);
    vec++; if (res != 6 || ov !== 1'b0) begin
      errs++; $display("FAIL ovf_cleared got=%0d/%b exp=6/0", res, ov);
    end
    accept_result();
  endtask

  task automatic test_len_zero();
    int lat, res, log0; bit ov;
    fill_random(15);
    log0 = addr_log.size();
    run_job(int'($urandom_range(0, DEPTH - 1)), 0, 1'b0, lat, res, ov);
    vec++; if (lat != 1) begin errs++; $display("FAIL len0_latency got=%0d exp=1", lat); end
    vec++; if (res != 0 || ov !== 1'b0) begin errs++; $display("FAIL len0_result got=%0d/%b exp=0/0", res, ov); end
    vec++; if (addr_log.size() != log0) begin
      errs++; $display("FAIL len0_bram_en got=%0d cycles exp=0", addr_log.size() - log0);
    end
    accept_result();
  endtask

  task automatic test_abort();
    int lat, res, eres, seen, base; bit ov, eov;
    fill_random(15);
    @(negedge clk);
    bus.base_addr = AW'($urandom_range(0, DEPTH - 1)); bus.len = 4'd5; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL abort_busy_before got=%b exp=1", bus.busy); end
    bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b0;
    vec++; if (bus.busy !== 1'b0 || bus.bram_en !== 1'b0) begin
      errs++; $display("FAIL abort_idle got=%b/%b exp=0/0", bus.busy, bus.bram_en);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) seen++;
    end
    vec++; if (seen != 0) begin errs++; $display("FAIL abort_no_result got=%0d exp=0", seen); end
    base = int'($urandom_range(0, DEPTH - 1));
    run_job(base, 3, 1'b1, lat, res, ov);
    model(base, 3, eres, eov);
    vec++; if (lat != 5 || res != eres || ov !== eov) begin
      errs++; $display("FAIL start_beats_abort got=%0d/%0d/%b exp=5/%0d/%b", lat, res, ov, eres, eov);
    end
    accept_result();
  endtask

  task automatic test_hold();
    int lat, res, eres, bad, base; bit ov, eov;
    fill_random(15);
    base = int'($urandom_range(0, DEPTH - 1));
    run_job(base, 6, 1'b0, lat, res, ov);
    model(base, 6, eres, eov);
    vec++; if (res != eres || ov !== eov) begin
      errs++; $display("FAIL hold_result got=%0d/%b exp=%0d/%b", res, ov, eres, eov);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.start = 1'b1; bus.len = 4'd3; bus.base_addr = AW'(i);
      @(posedge clk);
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || int'(bus.result) != eres || bus.ovf !== eov) bad++;
    end
    bus.start = 1'b0;
    vec++; if (bad != 0) begin errs++; $display("FAIL hold_stable got=%0d bad cycles exp=0", bad); end
    accept_result();
    vec++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      errs++; $display("FAIL hold_release got=%b/%b exp=0/0", bus.busy, bus.res_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    bus.base_addr = 3'd5; bus.len = 4'd8; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vec++; if ({bus.bram_en, bus.bram_addr, bus.busy, bus.res_valid, bus.result, bus.ovf} !== '0) begin
      errs++; $display("FAIL midrun_reset got en=%b addr=%0d busy=%b rv=%b res=%0d ovf=%b exp=all 0",
                       bus.bram_en, bus.bram_addr, bus.busy, bus.res_valid, bus.result, bus.ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int lat, res, eres, base, n, log0, bad, d, elat; bit ov, eov;
    for (int j = 0; j < 25; j++) begin
      fill_random(($urandom_range(0, 2) == 0) ? 15 : 7);
      base = int'($urandom_range(0, DEPTH - 1));
      n    = int'($urandom_range(0, DEPTH));
      elat = n + RD_LAT + 1;
      if (n == 0) elat = 1;
      log0 = addr_log.size();
      run_job(base, n, 1'b0, lat, res, ov);
      model(base, n, eres, eov);
      vec++; if (lat != elat || res != eres || ov !== eov) begin
        errs++; $display("FAIL random_job%0d base=%0d len=%0d got=%0d/%0d/%b exp=%0d/%0d/%b",
                         j, base, n, lat, res, ov, elat, eres, eov);
      end
      bad = (addr_log.size() - log0 != n) ? 1 : 0;
      for (int i = 0; i < n && log0 + i < addr_log.size(); i++)
        if (addr_log[log0 + i] != (base + i) % DEPTH) bad++;
      vec++; if (bad != 0) begin errs++; $display("FAIL random_addr%0d got=%0d errors exp=0", j, bad); end
      d = int'($urandom_range(0, 3));
      bad = 0;
      for (int i = 0; i < d; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (bus.res_valid !== 1'b1 || int'(bus.result) != res) bad++;
      end
      vec++; if (bad != 0) begin errs++; $display("FAIL random_hold%0d got=%0d exp=0", j, bad); end
      accept_result();
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_addr_wrap();
    test_overflow();
    test_len_zero();
    test_abort();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
